// File: rtl/byte_mem_responder.sv
// -----------------------------------------------------------------------------
// byte_mem_responder
//   Responder end of the byte-wide memory bus. Holds a synchronous byte RAM
//   and a small IO window: UART tx FIFO push / rx byte read at 0x30000 and
//   the program-halt register at 0x30004.
//
//   Optional feature macro: BYTE_MEM_RESP_HALT_EN
//     defined   : any write to 0x30004 sets the sticky program_halt flag
//     undefined : 0x30004 writes are ignored, program_halt is tied to 0
//
// Ports
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   rdy_in             global ready; low freezes bus-side state
//   mem_a/mem_wr/mem_dout  address, write strobe, write data from controller
//   mem_din            registered read data (1-cycle latency)
//   io_buffer_full     tx FIFO has fewer than IO_FREE_MIN free entries
//   tx_data/tx_valid/tx_ready  FIFO head to the UART transmitter
//   rx_data/rx_valid/rx_pop    received byte from the UART, consume pulse
//   program_halt       sticky halt flag
// -----------------------------------------------------------------------------
module byte_mem_responder #(
   parameter int RAM_ADDR_WIDTH    = 17,
   parameter int TX_FIFO_DEPTH_LOG = 3,
   parameter int IO_FREE_MIN       = 4
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        program_halt
);

   localparam int DEPTH = 1 << TX_FIFO_DEPTH_LOG;
   localparam int PW    = TX_FIFO_DEPTH_LOG;
   localparam int CW    = TX_FIFO_DEPTH_LOG + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // ---------------------------------------------------------------- decode
   // Only mem_a[17:0] matters; higher bits alias.
   logic                      is_io;
   logic                      sel_tx;
   logic                      sel_halt;
   logic [RAM_ADDR_WIDTH-1:0] ram_addr;
   logic                      unused_addr_bits;

   assign is_io            = (mem_a[17:16] == 2'b11);
   assign sel_tx           = is_io && (mem_a[15:0] == 16'h0000);
   assign sel_halt         = is_io && (mem_a[15:0] == 16'h0004);
   assign ram_addr         = mem_a[RAM_ADDR_WIDTH-1:0];
   assign unused_addr_bits = ^mem_a[31:18];

   // ------------------------------------------------------------------- RAM
   // Contents are not reset; a write caught by reset may or may not land.
   logic [7:0] ram [2**RAM_ADDR_WIDTH];

   always_ff @(posedge clk_in) begin
      if (rdy_in && mem_wr && !is_io)
         ram[ram_addr] <= mem_dout;
   end

   // --------------------------------------------------------------- tx FIFO
   logic [7:0]    fifo_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [CW-1:0] free_nxt;
   logic          push_req;
   logic          push_ok;
   logic          pop;

   assign tx_valid = (count != '0);
   assign tx_data  = fifo_mem[rd_ptr];
   assign pop      = tx_valid && tx_ready;
   assign push_req = rdy_in && mem_wr && sel_tx;
   // When full, a simultaneous pop frees the slot the push lands in.
   assign push_ok  = push_req && ((count != DEPTH_C) || pop);

   always_comb begin
      count_nxt = count;
      if (push_ok && !pop)
         count_nxt = count + CW'(1);
      else if (!push_ok && pop)
         count_nxt = count - CW'(1);
   end

   assign free_nxt = DEPTH_C - count_nxt;

   always_ff @(posedge clk_in) begin
      if (push_ok)
         fifo_mem[wr_ptr] <= mem_dout;
   end

   // Pops and io_buffer_full run regardless of rdy_in so the UART keeps
   // draining while the core stalls.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
         io_buffer_full <= 1'b0;
      end else begin
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         count          <= count_nxt;
         io_buffer_full <= (int'(free_nxt) < IO_FREE_MIN);
      end
   end

   // ---------------------------------------------------------- halt register
   logic halt_q;

`ifdef BYTE_MEM_RESP_HALT_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         halt_q <= 1'b0;
      else if (rdy_in && mem_wr && sel_halt)
         halt_q <= 1'b1;
   end
`else
   assign halt_q = 1'b0;
`endif

   assign program_halt = halt_q;

   // -------------------------------------------------------- read data path
   logic [7:0] io_rdata;

   always_comb begin
      io_rdata = 8'h00;
      if (!mem_wr) begin
         if (sel_tx)
            io_rdata = rx_valid ? rx_data : 8'h00;
         else if (sel_halt)
            io_rdata = {7'b0, halt_q};
      end
   end

   // RAM path reads the old byte even on a write (read-before-write).
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mem_din <= 8'h00;
         rx_pop  <= 1'b0;
      end else begin
         rx_pop <= rdy_in && !mem_wr && sel_tx && rx_valid;
         if (rdy_in)
            mem_din <= is_io ? io_rdata : ram[ram_addr];
      end
   end

endmodule

// File: tb/tb_byte_mem_responder.sv
module tb_byte_mem_responder;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        rdy_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_pop;
   logic        program_halt;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   byte_mem_responder dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
      .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_pop(rx_pop), .program_halt(program_halt)
   );

   // inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
      mem_a = a; mem_wr = wr; mem_dout = d;
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0; rdy_in = 1'b1; tx_ready = 1'b0;
      rx_valid = 1'b0; rx_data = 8'h00;
      bus(32'h0, 1'b0, 8'h00);
      step(); step();
      checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din got %h exp 00", mem_din); end
      checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_io_full got %b exp 0", io_buffer_full); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
      checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL reset_rx_pop got %b exp 0", rx_pop); end
      checks++; if (program_halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b exp 0", program_halt); end
      @(negedge clk_in); rst_n_in = 1'b1;
      step();
   endtask

   task automatic test_ram();
      bus(32'h10, 1'b1, 8'h11); step();
      bus(32'h11, 1'b1, 8'h5A); step();
      bus(32'h10, 1'b1, 8'hA5); step();
      checks++; if (mem_din !== 8'h11) begin errors++; $display("FAIL ram_rbw got %h exp 11", mem_din); end
      bus(32'h10, 1'b0, 8'h00);
      #1;
      checks++; if (mem_din !== 8'h11) begin errors++; $display("FAIL ram_latency_early got %h exp 11", mem_din); end
      step();
      checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_read10 got %h exp a5", mem_din); end
      bus(32'h11, 1'b0, 8'h00); step();
      checks++; if (mem_din !== 8'h5A) begin errors++; $display("FAIL ram_read11 got %h exp 5a", mem_din); end
   endtask

   task automatic test_alias();
      bus(32'h20010, 1'b1, 8'h3C); step();
      checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL alias_rbw got %h exp a5", mem_din); end
      bus(32'hFFFC_0010, 1'b0, 8'h00); step();
      checks++; if (mem_din !== 8'h3C) begin errors++; $display("FAIL alias_read got %h exp 3c", mem_din); end
   endtask

   task automatic test_stall();
      rdy_in = 1'b0;
      bus(32'h10, 1'b1, 8'h77); step();
      checks++; if (mem_din !== 8'h3C) begin errors++; $display("FAIL stall_hold got %h exp 3c", mem_din); end
      bus(32'h30000, 1'b1, 8'h99); step();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL stall_push got %b exp 0", tx_valid); end
      rdy_in = 1'b1;
      bus(32'h10, 1'b0, 8'h00); step();
      checks++; if (mem_din !== 8'h3C) begin errors++; $display("FAIL stall_nowrite got %h exp 3c", mem_din); end
   endtask

   task automatic test_fifo_fill();
      logic [7:0] exp;
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         exp = 8'h80 + 8'(i);
         bus(32'h30000, 1'b1, exp); step();
         checks++; if (io_buffer_full !== (i >= 4)) begin errors++; $display("FAIL fill_io_full[%0d] got %b exp %b", i, io_buffer_full, (i >= 4)); end
      end
      checks++; if (tx_data !== 8'h80 || tx_valid !== 1'b1) begin errors++; $display("FAIL fill_head got %h/%b exp 80/1", tx_data, tx_valid); end
      bus(32'h0, 1'b0, 8'h00);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp = 8'h80 + 8'(i);
         checks++; if (tx_valid !== 1'b1 || tx_data !== exp) begin errors++; $display("FAIL drain[%0d] got %h/%b exp %h/1", i, tx_data, tx_valid, exp); end
         step();
         checks++; if (io_buffer_full !== ((7 - i) > 4)) begin errors++; $display("FAIL drain_io_full[%0d] got %b exp %b", i, io_buffer_full, ((7 - i) > 4)); end
      end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", tx_valid); end
      tx_ready = 1'b0;
   endtask

   task automatic test_push_pop_full();
      logic [7:0] exp;
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus(32'h30000, 1'b1, 8'h90 + 8'(i)); step();
      end
      bus(32'h30000, 1'b1, 8'hA0); tx_ready = 1'b1;
      #1;
      checks++; if (tx_data !== 8'h90) begin errors++; $display("FAIL pp_head got %h exp 90", tx_data); end
      step();
      tx_ready = 1'b0;
      bus(32'h30000, 1'b1, 8'hB0); step();   // count is 8, so this drops
      checks++; if (io_buffer_full !== 1'b1 || tx_data !== 8'h91) begin errors++; $display("FAIL pp_after got %b/%h exp 1/91", io_buffer_full, tx_data); end
      bus(32'h0, 1'b0, 8'h00);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp = (i < 7) ? 8'h91 + 8'(i) : 8'hA0;
         checks++; if (tx_valid !== 1'b1 || tx_data !== exp) begin errors++; $display("FAIL pp_drain[%0d] got %h/%b exp %h/1", i, tx_data, tx_valid, exp); end
         step();
      end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got %b exp 0", tx_valid); end
      tx_ready = 1'b0;
   endtask

   task automatic test_rx();
      rx_valid = 1'b1; rx_data = 8'h41;
      bus(32'h30000, 1'b0, 8'h00);
      #1;
      checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rx_pop_early got %b exp 0", rx_pop); end
      step();
      checks++; if (mem_din !== 8'h41 || rx_pop !== 1'b1) begin errors++; $display("FAIL rx_read got %h/%b exp 41/1", mem_din, rx_pop); end
      bus(32'h0, 1'b0, 8'h00); step();
      checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rx_pulse_width got %b exp 0", rx_pop); end
      rdy_in = 1'b0;
      bus(32'h30000, 1'b0, 8'h00); step();
      checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rx_stall_pop got %b exp 0", rx_pop); end
      rdy_in = 1'b1; rx_valid = 1'b0;
      step();
      checks++; if (mem_din !== 8'h00 || rx_pop !== 1'b0) begin errors++; $display("FAIL rx_empty got %h/%b exp 00/0", mem_din, rx_pop); end
      rx_valid = 1'b1;
      bus(32'h30008, 1'b0, 8'h00); step();
      checks++; if (mem_din !== 8'h00 || rx_pop !== 1'b0) begin errors++; $display("FAIL io_other got %h/%b exp 00/0", mem_din, rx_pop); end
      rx_valid = 1'b0;
   endtask

   task automatic test_halt();
      logic exp_h;
`ifdef BYTE_MEM_RESP_HALT_EN
      exp_h = 1'b1;
`else
      exp_h = 1'b0;
`endif
      bus(32'h30004, 1'b1, 8'h00); step();
      checks++; if (program_halt !== exp_h) begin errors++; $display("FAIL halt_set got %b exp %b", program_halt, exp_h); end
      bus(32'h30004, 1'b0, 8'h00); step();
      checks++; if (mem_din !== {7'b0, exp_h}) begin errors++; $display("FAIL halt_read got %h exp %h", mem_din, {7'b0, exp_h}); end
      bus(32'h10, 1'b0, 8'h00); step();
      checks++; if (program_halt !== exp_h || mem_din !== 8'h3C) begin errors++; $display("FAIL halt_sticky got %b/%h exp %b/3c", program_halt, mem_din, exp_h); end
   endtask

   task automatic test_async_reset();
      tx_ready = 1'b0;
      bus(32'h30000, 1'b1, 8'h55); step();
      bus(32'h10, 1'b0, 8'h00); step();
      checks++; if (tx_valid !== 1'b1 || mem_din !== 8'h3C) begin errors++; $display("FAIL pre_reset got %b/%h exp 1/3c", tx_valid, mem_din); end
      #2 rst_n_in = 1'b0;
      #1;
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL async_tx_valid got %b exp 0", tx_valid); end
      checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL async_mem_din got %h exp 00", mem_din); end
      checks++; if (program_halt !== 1'b0) begin errors++; $display("FAIL async_halt got %b exp 0", program_halt); end
      checks++; if (io_buffer_full !== 1'b0 || rx_pop !== 1'b0) begin errors++; $display("FAIL async_misc got %b/%b exp 0/0", io_buffer_full, rx_pop); end
      @(negedge clk_in); rst_n_in = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_ram();
      test_alias();
      test_stall();
      test_fifo_fill();
      test_push_pop_full();
      test_rx();
      test_halt();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
